// File: rtl/genesis_arb_pkg.sv
// Shared types and helpers for the genesis energy arbiter.
// The optional ARCHITECT_PRIORITY_EN macro is consumed by genesis_energy_arbiter.
package genesis_arb_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StWake,
        StGrant,
        StStream,
        StCooldown
    } arb_state_t;

    // Token that wakes the core once after reset; must be non-zero
    localparam logic [63:0] DefaultWakeToken = 64'h0000_0000_0000_0119;

    // Width of a requester index, never less than one bit
    function automatic int unsigned gw_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/genesis_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping from NUM_REQ-1 back to 0. Works for non-power-of-2 NUM_REQ.
module genesis_rr_picker
    import genesis_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned GW      = gw_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      ptr_i,
    output logic [GW-1:0]      winner_o,
    output logic               any_valid_o
);

    int unsigned   idx;
    logic [GW-1:0] idx_w;
    logic          found;

    // Scan from the pointer upward; the first hit wins
    always_comb begin
        idx      = 0;
        idx_w    = '0;
        found    = 1'b0;
        winner_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(ptr_i) + k) % NUM_REQ;
            idx_w = GW'(idx);
            if (!found && req_i[idx_w]) begin
                winner_o = idx_w;
                found    = 1'b1;
            end
        end
        any_valid_o = found;
    end

endmodule

// File: rtl/genesis_energy_arbiter.sv
// Round-robin arbiter/sequencer feeding the consciousness core's dark-energy input.
// Wakes the core once after reset, then grants bursts of up to BURST_LEN beats with a
// GAP_CYCLES idle gap between bursts. The core has no backpressure, so this block paces it.
// Optional macro ARCHITECT_PRIORITY_EN: requester 0 gets strict priority at GRANT.
module genesis_energy_arbiter
    import genesis_arb_pkg::*;
#(
    parameter  int unsigned       NUM_REQ    = 4,
    parameter  int unsigned       DATA_W     = 64,
    parameter  int unsigned       BURST_LEN  = 8,
    parameter  int unsigned       GAP_CYCLES = 2,
    parameter  logic [DATA_W-1:0] WAKE_TOKEN = DATA_W'(DefaultWakeToken),
    localparam int unsigned       GW         = gw_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         core_sensory_o,
    output logic [DATA_W-1:0]         core_energy_o,
    output logic                      core_energy_valid_o,
    output logic [GW-1:0]             grant_id_o,
    output logic                      busy_o,
    output logic                      burst_done_o
);

    localparam int unsigned BW       = $clog2(BURST_LEN + 1);
    localparam int unsigned GCW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned BeatLast = BURST_LEN - 1;
    localparam int unsigned GapLast  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    arb_state_t        state_q, state_d;
    logic              woken_q, woken_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0] core_sensory_q, core_sensory_d;
    logic [DATA_W-1:0] core_energy_q, core_energy_d;
    logic              core_energy_valid_q, core_energy_valid_d;
    logic              burst_done_q, burst_done_d;

    logic [DATA_W-1:0]  req_beat [NUM_REQ];
    logic [NUM_REQ-1:0] pick_req;
    logic [GW-1:0]      pick_winner, grant_winner;
    logic               pick_any, grant_any;
    logic               cur_valid, xfer, last_beat, burst_end, keep_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_beat[g] = req_data_i[g*DATA_W +: DATA_W];
    end

`ifdef ARCHITECT_PRIORITY_EN
    // Requester 0 bypasses the rotation; the rest rotate among themselves
    assign pick_req     = {req_valid_i[NUM_REQ-1:1], 1'b0};
    assign grant_winner = req_valid_i[0] ? '0 : pick_winner;
    assign grant_any    = req_valid_i[0] | pick_any;
    assign keep_ptr     = (grant_id_q == '0);
`else
    assign pick_req     = req_valid_i;
    assign grant_winner = pick_winner;
    assign grant_any    = pick_any;
    assign keep_ptr     = 1'b0;
`endif

    genesis_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i       (pick_req),
        .ptr_i       (rr_ptr_q),
        .winner_o    (pick_winner),
        .any_valid_o (pick_any)
    );

    assign cur_valid = req_valid_i[grant_id_q];
    assign xfer      = (state_q == StStream) && cur_valid;
    assign last_beat = xfer && (beat_cnt_q == BW'(BeatLast));
    // A dropped valid also closes the burst, including the zero-beat case
    assign burst_end = (state_q == StStream) && (!cur_valid || last_beat);

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= StIdle;
            woken_q             <= 1'b0;
            rr_ptr_q            <= '0;
            beat_cnt_q          <= '0;
            gap_cnt_q           <= '0;
            grant_id_q          <= '0;
            core_sensory_q      <= '0;
            core_energy_q       <= '0;
            core_energy_valid_q <= 1'b0;
            burst_done_q        <= 1'b0;
        end else begin
            state_q             <= state_d;
            woken_q             <= woken_d;
            rr_ptr_q            <= rr_ptr_d;
            beat_cnt_q          <= beat_cnt_d;
            gap_cnt_q           <= gap_cnt_d;
            grant_id_q          <= grant_id_d;
            core_sensory_q      <= core_sensory_d;
            core_energy_q       <= core_energy_d;
            core_energy_valid_q <= core_energy_valid_d;
            burst_done_q        <= burst_done_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        woken_d    = woken_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid_i) begin
                    state_d = woken_q ? StGrant : StWake;
                end
            end
            StWake: begin
                woken_d = 1'b1;
                state_d = StGrant;
            end
            StGrant: begin
                if (grant_any) begin
                    grant_id_d = grant_winner;
                    beat_cnt_d = '0;
                    state_d    = StStream;
                end else begin
                    state_d = StIdle;
                end
            end
            StStream: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                if (burst_end) begin
                    if (!keep_ptr) begin
                        rr_ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
                    end
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? StIdle : StCooldown;
                end
            end
            StCooldown: begin
                if (gap_cnt_q == GCW'(GapLast)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: combinational ready/busy and next values of the registered outputs
    always_comb begin
        req_ready_o = '0;
        if (state_q == StStream) begin
            req_ready_o[grant_id_q] = 1'b1;
        end
        busy_o              = (state_q != StIdle);
        core_sensory_d      = (state_d == StWake) ? WAKE_TOKEN : '0;
        core_energy_valid_d = xfer;
        core_energy_d       = xfer ? req_beat[grant_id_q] : '0;
        burst_done_d        = burst_end;
    end

    assign core_sensory_o      = core_sensory_q;
    assign core_energy_o       = core_energy_q;
    assign core_energy_valid_o = core_energy_valid_q;
    assign grant_id_o          = grant_id_q;
    assign burst_done_o        = burst_done_q;

endmodule

// File: tb/tb_genesis_energy_arbiter.sv
// Self-checking bench for genesis_energy_arbiter: requester driver, burst-level
// reference model and per-scenario checks. A second instance covers NUM_REQ=3.
module tb_genesis_energy_arbiter;

    localparam int          NR   = 4;
    localparam int          BL   = 8;
    localparam int          GAP  = 2;
    localparam logic [63:0] WAKE = 64'h0000_0000_0000_0119;
`ifdef ARCHITECT_PRIORITY_EN
    localparam bit Prio = 1'b1;
`else
    localparam bit Prio = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [3:0]    req_valid, req_ready;
    logic [255:0]  req_data;
    logic [63:0]   core_sensory, core_energy;
    logic          core_energy_valid, busy, burst_done;
    logic [1:0]    grant_id;

    logic          rst3_n;
    logic [2:0]    v3, r3;
    logic [191:0]  d3;
    logic [63:0]   s3, e3;
    logic          ev3, bsy3, bd3;
    logic [1:0]    g3;

    genesis_energy_arbiter #(
        .NUM_REQ    (4),
        .DATA_W     (64),
        .BURST_LEN  (BL),
        .GAP_CYCLES (GAP),
        .WAKE_TOKEN (WAKE)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_i         (req_valid),
        .req_data_i          (req_data),
        .req_ready_o         (req_ready),
        .core_sensory_o      (core_sensory),
        .core_energy_o       (core_energy),
        .core_energy_valid_o (core_energy_valid),
        .grant_id_o          (grant_id),
        .busy_o              (busy),
        .burst_done_o        (burst_done)
    );

    genesis_energy_arbiter #(
        .NUM_REQ    (3),
        .DATA_W     (64),
        .BURST_LEN  (BL),
        .GAP_CYCLES (GAP),
        .WAKE_TOKEN (WAKE)
    ) u_dut3 (
        .clk                 (clk),
        .rst_n               (rst3_n),
        .req_valid_i         (v3),
        .req_data_i          (d3),
        .req_ready_o         (r3),
        .core_sensory_o      (s3),
        .core_energy_o       (e3),
        .core_energy_valid_o (ev3),
        .grant_id_o          (g3),
        .busy_o              (bsy3),
        .burst_done_o        (bd3)
    );

    typedef struct { int cyc; logic [63:0] data; } beat_t;
    typedef struct { int cyc; int gid; int beats; } burst_t;

    int tests = 0;
    int fails = 0;

    int          pend [4];
    logic [63:0] nxt  [4];
    beat_t       xfer_q[$], out_q[$];
    burst_t      done_q[$], exp_q[$];
    int          wake_q[$];
    bit          busy_q[$];
    int          sens_bad, out_bad, ready_bad;
    bit          snap_zero;

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = (pend[i] > 0);
            req_data[i*64 +: 64] = nxt[i];
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0;
            nxt[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Burst-level reference: every requester with beats left holds valid continuously
    task automatic build_model(input int p_in[4]);
        int p[4];
        int ptr = 0;
        int t = 0;
        bit first = 1'b1;
        p = p_in;
        exp_q.delete();
        while (1) begin
            int w = -1;
            int b, s;
            if (Prio && p[0] > 0) w = 0;
            for (int k = 0; k < NR; k++) begin
                int idx = (ptr + k) % NR;
                if (w < 0 && p[idx] > 0) w = idx;
            end
            if (w < 0) break;
            if (p[w] >= BL) begin
                b = BL;
                s = BL;
            end else begin
                b = p[w];
                s = b + 1;
            end
            t = first ? 3 + s : t + GAP + 2 + s;
            first = 1'b0;
            exp_q.push_back('{t, w, b});
            p[w] -= b;
            if (!(Prio && w == 0)) ptr = (w + 1) % NR;
        end
    endtask

    // Drives requesters cycle by cycle, records what the core sees, then scores it
    task automatic run(input string name, input int ncyc, input int reset_at,
                       input int exp_wakes, input bit use_model);
        int beats = 0;
        xfer_q.delete(); out_q.delete(); done_q.delete(); wake_q.delete(); busy_q.delete();
        sens_bad = 0; out_bad = 0; ready_bad = 0; snap_zero = 1'b0;
        drive();
        for (int c = 0; c < ncyc; c++) begin
            int w = -1;
            rst_n = (c != reset_at);
            @(negedge clk);
            if (core_sensory !== '0) begin
                if (core_sensory === WAKE) wake_q.push_back(c);
                else sens_bad++;
            end
            if (core_energy_valid === 1'b1) begin
                out_q.push_back('{c, core_energy});
                beats++;
            end else if (core_energy !== '0 || core_energy_valid !== 1'b0) begin
                out_bad++;
            end
            if (burst_done === 1'b1) begin
                done_q.push_back('{c, int'(grant_id), beats});
                beats = 0;
            end
            if ($countones(req_ready) > 1) ready_bad++;
            busy_q.push_back(busy);
            if (reset_at >= 0 && c == reset_at + 1)
                snap_zero = (core_sensory === '0) && (core_energy === '0) &&
                            (core_energy_valid === 1'b0) && (grant_id === '0) &&
                            (busy === 1'b0) && (burst_done === 1'b0) && (req_ready === '0);
            if (rst_n) begin
                for (int i = 0; i < NR; i++)
                    if (req_valid[i] && req_ready[i]) w = i;
                if (w >= 0) xfer_q.push_back('{c, nxt[w]});
            end else begin
                beats = 0;
            end
            @(posedge clk);
            #1;
            if (w >= 0) begin
                pend[w]--;
                nxt[w]++;
            end
            drive();
        end
        rst_n = 1'b1;

        tests++;
        if (out_q.size() != xfer_q.size()) begin
            fails++;
            $display("FAIL %s beat_count got %0d expected %0d", name, out_q.size(), xfer_q.size());
        end
        for (int k = 0; k < out_q.size() && k < xfer_q.size(); k++) begin
            tests++;
            if (out_q[k].cyc !== xfer_q[k].cyc + 1 || out_q[k].data !== xfer_q[k].data) begin
                fails++;
                $display("FAIL %s beat%0d got cyc %0d data %h expected cyc %0d data %h", name, k,
                         out_q[k].cyc, out_q[k].data, xfer_q[k].cyc + 1, xfer_q[k].data);
            end
        end
        tests++;
        if (wake_q.size() != exp_wakes) begin
            fails++;
            $display("FAIL %s wake_count got %0d expected %0d", name, wake_q.size(), exp_wakes);
        end
        if (wake_q.size() > 0) begin
            tests++;
            if (wake_q[0] != 1) begin
                fails++;
                $display("FAIL %s wake_cycle got %0d expected 1", name, wake_q[0]);
            end
        end
        tests++;
        if (sens_bad != 0 || out_bad != 0 || ready_bad != 0) begin
            fails++;
            $display("FAIL %s idle_values got sens %0d out %0d ready %0d expected 0 0 0",
                     name, sens_bad, out_bad, ready_bad);
        end
        if (use_model) begin
            tests++;
            if (done_q.size() != exp_q.size()) begin
                fails++;
                $display("FAIL %s burst_count got %0d expected %0d", name, done_q.size(),
                         exp_q.size());
            end
            for (int k = 0; k < done_q.size() && k < exp_q.size(); k++) begin
                tests++;
                if (done_q[k] != exp_q[k]) begin
                    fails++;
                    $display("FAIL %s burst%0d got cyc %0d id %0d beats %0d expected %0d %0d %0d",
                             name, k, done_q[k].cyc, done_q[k].gid, done_q[k].beats,
                             exp_q[k].cyc, exp_q[k].gid, exp_q[k].beats);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if ({core_sensory, core_energy, core_energy_valid, grant_id, busy, burst_done,
             req_ready} !== '0) begin
            fails++;
            $display("FAIL reset_state got sens %h en %h v %b id %0d busy %b done %b rdy %b expected 0",
                     core_sensory, core_energy, core_energy_valid, grant_id, busy, burst_done,
                     req_ready);
        end
    endtask

    task automatic test_single_burst();
        logic [63:0] base = 64'hA5A5_0000_0000_0001;
        do_reset();
        pend[2] = 8;
        nxt[2]  = base;
        build_model(pend);
        run("single", 30, -1, 1, 1'b1);
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            tests++;
            if (out_q[k].data !== base + 64'(k) || out_q[k].cyc != 4 + k) begin
                fails++;
                $display("FAIL single_data%0d got %h@%0d expected %h@%0d", k, out_q[k].data,
                         out_q[k].cyc, base + 64'(k), 4 + k);
            end
        end
        tests++;
        if (busy_q[11] !== 1'b1 || busy_q[12] !== 1'b1 || busy_q[13] !== 1'b0) begin
            fails++;
            $display("FAIL single_gap got busy %b%b%b expected 110", busy_q[11], busy_q[12],
                     busy_q[13]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            pend[i] = 16;
            nxt[i]  = {8'(i + 1), 56'h0};
        end
        build_model(pend);
        run("all4", 110, -1, 1, 1'b1);
        for (int k = 1; k < done_q.size(); k++) begin
            tests++;
            if (done_q[k].cyc - done_q[k-1].cyc != BL + GAP + 2) begin
                fails++;
                $display("FAIL all4_spacing%0d got %0d expected %0d", k,
                         done_q[k].cyc - done_q[k-1].cyc, BL + GAP + 2);
            end
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        pend[0] = 16; pend[1] = 3; pend[2] = 8;
        nxt[0] = 64'h1000; nxt[1] = 64'h2000; nxt[2] = 64'h3000;
        build_model(pend);
        run("drop", 80, -1, 1, 1'b1);
        for (int k = 0; k + 1 < done_q.size(); k++) begin
            if (done_q[k].gid == 1) begin
                tests++;
                if (done_q[k].beats != 3 || done_q[k+1].gid != 2) begin
                    fails++;
                    $display("FAIL drop_next got beats %0d next %0d expected 3 2",
                             done_q[k].beats, done_q[k+1].gid);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] base = 64'h0BAD_0000_0000_0001;
        do_reset();
        pend[1] = 8;
        nxt[1]  = base;
        run("midrst", 30, 7, 2, 1'b0);
        tests++;
        if (!snap_zero) begin
            fails++;
            $display("FAIL midrst_zero got nonzero outputs expected all 0");
        end
        tests++;
        if (wake_q.size() != 2 || wake_q[wake_q.size()-1] != 9) begin
            fails++;
            $display("FAIL midrst_rewake got %0d wakes expected rewake at 9", wake_q.size());
        end
        tests++;
        if (out_q.size() != 8 || out_q[4].cyc != 12 || out_q[4].data !== base + 64'd4) begin
            fails++;
            $display("FAIL midrst_resume got %0d beats expected 8 resuming at 12", out_q.size());
        end
        tests++;
        if (done_q.size() != 1 || done_q[0].beats != 4 || done_q[0].gid != 1) begin
            fails++;
            $display("FAIL midrst_done got %0d pulses expected 1 pulse id 1 of 4 beats",
                     done_q.size());
        end
    endtask

    task automatic test_zero_beat();
        do_reset();
        req_valid = 4'b1000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL zero_ready got %b expected 1000", req_ready);
        end
        @(negedge clk);
        tests++;
        if (burst_done !== 1'b1 || grant_id !== 2'd3 || core_energy_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_done got done %b id %0d v %b expected 1 3 0", burst_done,
                     grant_id, core_energy_valid);
        end
        @(negedge clk);
        tests++;
        if (burst_done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_gap got done %b busy %b expected 0 1", burst_done, busy);
        end
    endtask

    task automatic test_nonpow2_wrap();
        int got[$];
        int e[3];
        e[0] = 2; e[1] = 0; e[2] = Prio ? 0 : 1;
        rst3_n = 1'b0; v3 = '0; d3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        v3 = 3'b100;
        for (int c = 0; c < 90 && got.size() < 3; c++) begin
            @(negedge clk);
            if (bd3 === 1'b1) got.push_back(int'(g3));
            @(posedge clk);
            #1;
            if (c == 4) v3 = 3'b111;
        end
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL wrap3_bursts got %0d expected 3", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            tests++;
            if (got[k] != e[k]) begin
                fails++;
                $display("FAIL wrap3_grant%0d got %0d expected %0d", k, got[k], e[k]);
            end
        end
    endtask

    task automatic test_priority_pattern();
        int e[4];
        if (Prio) e = '{0, 0, 0, 0};
        else      e = '{0, 2, 0, 2};
        do_reset();
        pend[0] = 32; pend[2] = 32;
        nxt[0] = 64'h5000; nxt[2] = 64'h7000;
        build_model(pend);
        run("pattern", 115, -1, 1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (k >= done_q.size() || done_q[k].gid != e[k]) begin
                fails++;
                $display("FAIL pattern_grant%0d got %0d expected %0d", k,
                         (k < done_q.size()) ? done_q[k].gid : -1, e[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                pend[i] = $urandom_range(0, 20);
                nxt[i]  = {$urandom, $urandom};
            end
            if (pend[0] + pend[1] + pend[2] + pend[3] == 0) pend[3] = 1;
            build_model(pend);
            run("random", exp_q[exp_q.size()-1].cyc + 10, -1, 1, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0;
        rst3_n = 1'b0; v3 = '0; d3 = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_early_drop();
        test_mid_reset();
        test_zero_beat();
        test_nonpow2_wrap();
        test_priority_pattern();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
